// File: rtl/key_debounce_bank.sv
// Multi-channel key debouncer: per-channel 2-FF synchroniser, stability counter,
// debounced level with press/release strobes and an optional hold/auto-repeat strobe.
module key_debounce_bank #(
   parameter int CHANNELS        = 4,
   parameter int DEBOUNCE_CYCLES = 1000000,
   parameter int ACTIVE_LOW      = 0,
   parameter int REPEAT_EN       = 0,
   parameter int HOLD_CYCLES     = 50000000,
   parameter int REPEAT_CYCLES   = 10000000
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [CHANNELS-1:0] key_in,
   output logic [CHANNELS-1:0] key_level,
   output logic [CHANNELS-1:0] key_press,
   output logic [CHANNELS-1:0] key_release,
   output logic [CHANNELS-1:0] key_repeat
);

   localparam int            CW       = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0] DB_TC    = CW'(DEBOUNCE_CYCLES - 1);
   // Sync flops hold the raw pin, so their idle value is the released pin level.
   localparam logic          SYNC_RST = (ACTIVE_LOW != 0);

   // state     | meaning
   // ST_IDLE   | key released, no repeat activity
   // ST_HOLD   | key pressed, timing the initial hold delay
   // ST_REPEAT | hold delay elapsed, emitting periodic repeat strobes
   typedef enum logic [1:0] {ST_IDLE, ST_HOLD, ST_REPEAT} rpt_state_e;

   for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
      logic          s1_q, s2_q;
      logic          pressed_s;
      logic [CW-1:0] cnt_q, cnt_d;
      logic          lvl_q, lvl_d;
      logic          press_q, press_d;
      logic          rel_q, rel_d;

      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            s1_q    <= SYNC_RST;
            s2_q    <= SYNC_RST;
            cnt_q   <= '0;
            lvl_q   <= 1'b0;
            press_q <= 1'b0;
            rel_q   <= 1'b0;
         end else begin
            s1_q    <= key_in[g];
            s2_q    <= s1_q;
            cnt_q   <= cnt_d;
            lvl_q   <= lvl_d;
            press_q <= press_d;
            rel_q   <= rel_d;
         end
      end

      assign pressed_s = (ACTIVE_LOW != 0) ? ~s2_q : s2_q;

      always_comb begin
         cnt_d   = cnt_q;
         lvl_d   = lvl_q;
         press_d = 1'b0;
         rel_d   = 1'b0;
         if (pressed_s == lvl_q) begin
            cnt_d = '0;
         end else if (cnt_q == DB_TC) begin
            cnt_d   = '0;
            lvl_d   = pressed_s;
            press_d = pressed_s;
            rel_d   = ~pressed_s;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end

      assign key_level[g]   = lvl_q;
      assign key_press[g]   = press_q;
      assign key_release[g] = rel_q;

      if (REPEAT_EN != 0) begin : g_rpt
         localparam int            RMAX    = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
         localparam int            RW      = $clog2(RMAX + 1);
         localparam logic [RW-1:0] HOLD_TC = RW'(HOLD_CYCLES - 1);
         localparam logic [RW-1:0] REP_TC  = RW'(REPEAT_CYCLES - 1);

         rpt_state_e    st_q, st_d;
         logic [RW-1:0] rcnt_q, rcnt_d;
         logic          rep_q, rep_d;

         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               st_q   <= ST_IDLE;
               rcnt_q <= '0;
               rep_q  <= 1'b0;
            end else begin
               st_q   <= st_d;
               rcnt_q <= rcnt_d;
               rep_q  <= rep_d;
            end
         end

         always_comb begin
            st_d   = st_q;
            rcnt_d = rcnt_q;
            case (st_q)
               ST_IDLE: begin
                  if (press_d) begin
                     st_d   = ST_HOLD;
                     rcnt_d = '0;
                  end
               end
               ST_HOLD: begin
                  if (rel_d) begin
                     st_d   = ST_IDLE;
                     rcnt_d = '0;
                  end else if (rcnt_q == HOLD_TC) begin
                     st_d   = ST_REPEAT;
                     rcnt_d = '0;
                  end else begin
                     rcnt_d = rcnt_q + 1'b1;
                  end
               end
               ST_REPEAT: begin
                  if (rel_d) begin
                     st_d   = ST_IDLE;
                     rcnt_d = '0;
                  end else if (rcnt_q == REP_TC) begin
                     rcnt_d = '0;
                  end else begin
                     rcnt_d = rcnt_q + 1'b1;
                  end
               end
               default: begin
                  st_d   = ST_IDLE;
                  rcnt_d = '0;
               end
            endcase
         end

         // Release wins over a repeat falling on the same edge.
         always_comb begin
            rep_d = 1'b0;
            if (!rel_d) begin
               if (st_q == ST_HOLD && rcnt_q == HOLD_TC)
                  rep_d = 1'b1;
               else if (st_q == ST_REPEAT && rcnt_q == REP_TC)
                  rep_d = 1'b1;
            end
         end

         assign key_repeat[g] = rep_q;
      end else begin : g_norpt
         assign key_repeat[g] = 1'b0;
      end
   end

endmodule
